// File: rtl/kb_pkg.sv
// Shared types and constants for the PS/2 multi-key decoder: prefix FSM states,
// prefix bytes and the scan codes of the game keys.
package kb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } kb_state_t;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  localparam logic [7:0] KC_W     = 8'h1D;
  localparam logic [7:0] KC_A     = 8'h1C;
  localparam logic [7:0] KC_S     = 8'h1B;
  localparam logic [7:0] KC_D     = 8'h23;
  localparam logic [7:0] KC_R     = 8'h2D;
  localparam logic [7:0] KC_ENTER = 8'h5A;

  // Table entry: bit 8 is the E0 flag, bits 7:0 the scan code.
  function automatic logic [8:0] key_entry(input logic ext, input logic [7:0] code);
    return {ext, code};
  endfunction

endpackage

// File: rtl/kb_repeat_timer.sv
// Software typematic timer: follows the most recently pressed key and pulses its
// repeat bit after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles while held.
module kb_repeat_timer #(
  parameter int NUM_KEYS      = 6,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] press,
  input  logic [NUM_KEYS-1:0] held,
  output logic [NUM_KEYS-1:0] repeat_tick
);

  localparam int CMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  logic [CW-1:0] cnt;
  logic [IW-1:0] last_idx;
  logic [IW-1:0] press_idx;
  logic          active;
  logic          first;
  logic          hit;

  // Simultaneous presses: the highest index becomes the target.
  always_comb begin
    press_idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (press[i]) press_idx = IW'(i);
    end
  end

  assign hit = active && (first ? (cnt == CW'(REPEAT_DELAY - 1))
                                : (cnt == CW'(REPEAT_PERIOD - 1)));

  // press/held are the next-cycle key state, so the count is 0 in the press-tick cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      last_idx    <= '0;
      active      <= 1'b0;
      first       <= 1'b0;
      repeat_tick <= '0;
    end else begin
      repeat_tick <= '0;
      if (|press) begin
        last_idx <= press_idx;
        cnt      <= '0;
        active   <= 1'b1;
        first    <= 1'b1;
      end else if (active && !held[last_idx]) begin
        active <= 1'b0;
      end else if (active) begin
        if (hit) begin
          repeat_tick[last_idx] <= 1'b1;
          cnt                   <= '0;
          first                 <= 1'b0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/kb_multi_decoder.sv
// PS/2 scan-code decoder tracking NUM_KEYS held keys with press/release ticks, 1-cycle latency.
// Optional software typematic repeat is built when KB_REPEAT_EN is defined.
module kb_multi_decoder
  import kb_pkg::*;
#(
  parameter int                       NUM_KEYS      = 6,
  parameter logic [NUM_KEYS*9-1:0]    KEY_CODES     = {1'b0, KC_ENTER, 1'b0, KC_R, 1'b0, KC_S,
                                                       1'b0, KC_W, 1'b0, KC_D, 1'b0, KC_A},
  parameter int                       REPEAT_DELAY  = 25_000_000,
  parameter int                       REPEAT_PERIOD = 5_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                scan_done_tick,
  input  logic [7:0]          scan_code,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press_tick,
  output logic [NUM_KEYS-1:0] key_release_tick,
  output logic [NUM_KEYS-1:0] key_repeat_tick,
  output logic                any_held
);

  kb_state_t           state, state_nxt;
  logic                make_ev, brk_ev;
  logic [8:0]          ev_code;
  logic [NUM_KEYS-1:0] match, held_nxt, press_nxt, release_nxt;

  always_comb begin
    state_nxt = state;
    make_ev   = 1'b0;
    brk_ev    = 1'b0;
    ev_code   = key_entry(1'b0, scan_code);
    if (scan_done_tick) begin
      case (state)
        ST_IDLE: begin
          if (scan_code == SC_EXT)      state_nxt = ST_EXT;
          else if (scan_code == SC_BRK) state_nxt = ST_BRK;
          else                          make_ev   = 1'b1;
        end
        ST_EXT: begin
          ev_code = key_entry(1'b1, scan_code);
          if (scan_code == SC_BRK) begin
            state_nxt = ST_EXT_BRK;
          end else if (scan_code != SC_EXT) begin
            make_ev   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          brk_ev    = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_EXT_BRK: begin
          ev_code   = key_entry(1'b1, scan_code);
          brk_ev    = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Every table entry equal to the event code is hit, so duplicates move together.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      match[i] = (KEY_CODES[9*i +: 9] == ev_code);
    end
  end

  always_comb begin
    held_nxt = key_held;
    if (make_ev)     held_nxt = key_held | match;
    else if (brk_ev) held_nxt = key_held & ~match;
    press_nxt   = held_nxt & ~key_held;
    release_nxt = key_held & ~held_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      key_held         <= '0;
      key_press_tick   <= '0;
      key_release_tick <= '0;
      any_held         <= 1'b0;
    end else begin
      state            <= state_nxt;
      key_held         <= held_nxt;
      key_press_tick   <= press_nxt;
      key_release_tick <= release_nxt;
      any_held         <= |held_nxt;
    end
  end

`ifdef KB_REPEAT_EN
  kb_repeat_timer #(
    .NUM_KEYS      (NUM_KEYS),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_repeat (
    .clk         (clk),
    .reset       (reset),
    .press       (press_nxt),
    .held        (held_nxt),
    .repeat_tick (key_repeat_tick)
  );
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0]};
  assign key_repeat_tick   = '0;
`endif

endmodule

// File: tb/tb_kb_multi_decoder.sv
// Self-checking bench for kb_multi_decoder: a behavioural model pushes expected outputs
// per byte into a scoreboard queue, popped and compared once the DUT has registered them.
module tb_kb_multi_decoder;

  localparam int NK = 7;
  // Key 6 is the extended twin of W (E0 1D).
  localparam logic [NK*9-1:0] CODES = {9'h11D, 9'h05A, 9'h02D, 9'h01B, 9'h01D, 9'h023, 9'h01C};

  typedef struct packed {
    logic [NK-1:0] held;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic [NK-1:0] rep;
    logic          any;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          scan_done_tick = 1'b0;
  logic [7:0]    scan_code = 8'h00;
  logic [NK-1:0] key_held, key_press_tick, key_release_tick, key_repeat_tick;
  logic          any_held;

  kb_multi_decoder #(
    .NUM_KEYS      (NK),
    .KEY_CODES     (CODES),
    .REPEAT_DELAY  (20),
    .REPEAT_PERIOD (5)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .scan_done_tick   (scan_done_tick),
    .scan_code        (scan_code),
    .key_held         (key_held),
    .key_press_tick   (key_press_tick),
    .key_release_tick (key_release_tick),
    .key_repeat_tick  (key_repeat_tick),
    .any_held         (any_held)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            failures = 0;
  obs_t          sb[$];
  logic [NK-1:0] m_held = '0;
  int            m_st = 0;  // 0 idle, 1 ext, 2 brk, 3 ext+brk

  function automatic obs_t observe();
    return {key_held, key_press_tick, key_release_tick, key_repeat_tick, any_held};
  endfunction

  function automatic logic [NK-1:0] tb_match(input logic [8:0] c);
    logic [NK-1:0] m;
    for (int i = 0; i < NK; i++) m[i] = (CODES[9*i +: 9] == c);
    return m;
  endfunction

  // Called at a negedge; drives one byte for one cycle and returns at the next negedge.
  task automatic push_byte(input logic [7:0] b);
    logic          mk, bk;
    logic [8:0]    c;
    logic [NK-1:0] nh;
    obs_t          e;
    mk = 1'b0; bk = 1'b0; c = {1'b0, b};
    case (m_st)
      0: if (b == 8'hE0) m_st = 1; else if (b == 8'hF0) m_st = 2; else mk = 1'b1;
      1: begin
        c = {1'b1, b};
        if (b == 8'hF0) m_st = 3;
        else if (b != 8'hE0) begin mk = 1'b1; m_st = 0; end
      end
      2: begin bk = 1'b1; m_st = 0; end
      default: begin c = {1'b1, b}; bk = 1'b1; m_st = 0; end
    endcase
    nh = m_held;
    if (mk) nh = m_held | tb_match(c);
    if (bk) nh = m_held & ~tb_match(c);
    e.held  = nh;
    e.press = nh & ~m_held;
    e.rel   = m_held & ~nh;
    e.rep   = '0;
    e.any   = |nh;
    m_held  = nh;
    sb.push_back(e);
    scan_done_tick = 1'b1;
    scan_code      = b;
    @(negedge clk);
    scan_done_tick = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_held = '0; m_st = 0;
    o = observe();
    checks++;
    if (o !== '0) begin failures++; $display("FAIL reset_state got=%h exp=0", o); end
  endtask

  task automatic test_press_release();
    logic [7:0] seq[3] = '{8'h1C, 8'hF0, 8'h1C};
    obs_t e, o;
    foreach (seq[k]) begin
      push_byte(seq[k]);
      e = sb.pop_front(); o = observe();
      checks++;
      if (o !== e) begin failures++; $display("FAIL press_release byte=%h got=%h exp=%h", seq[k], o, e); end
      if (k == 0) begin
        checks++;
        if (key_press_tick[0] !== 1'b1 || key_held[0] !== 1'b1)
          begin failures++; $display("FAIL press_a press=%b held=%b exp 1 1", key_press_tick[0], key_held[0]); end
        @(negedge clk);
        checks++;
        if (key_press_tick !== '0 || key_held[0] !== 1'b1)
          begin failures++; $display("FAIL press_a_one_cycle press=%b held=%b", key_press_tick, key_held[0]); end
      end
    end
    checks++;
    if (key_release_tick[0] !== 1'b1 || key_held[0] !== 1'b0 || any_held !== 1'b0)
      begin failures++; $display("FAIL release_a rel=%b held=%b any=%b", key_release_tick[0], key_held[0], any_held); end
  endtask

  task automatic test_typematic();
    logic [7:0] seq[5] = '{8'h1D, 8'h1D, 8'h1D, 8'hF0, 8'h1D};
    obs_t e, o;
    int   npress = 0;
    foreach (seq[k]) begin
      push_byte(seq[k]);
      e = sb.pop_front(); o = observe();
      if (key_press_tick[2]) npress++;
      checks++;
      if (o !== e) begin failures++; $display("FAIL typematic byte=%0d got=%h exp=%h", k, o, e); end
      if (k == 2) begin
        checks++;
        if (key_held[2] !== 1'b1) begin failures++; $display("FAIL typematic_held got=%b exp=1", key_held[2]); end
      end
    end
    checks++;
    if (npress != 1) begin failures++; $display("FAIL typematic_press_count got=%0d exp=1", npress); end
  endtask

  task automatic test_extended();
    logic [7:0] seq[7] = '{8'hE0, 8'h1D, 8'h1D, 8'hE0, 8'hF0, 8'h1D, 8'hF0};
    obs_t e, o;
    foreach (seq[k]) begin
      push_byte(seq[k]);
      e = sb.pop_front(); o = observe();
      checks++;
      if (o !== e) begin failures++; $display("FAIL extended byte=%0d got=%h exp=%h", k, o, e); end
      if (k == 1) begin
        checks++;
        if (key_held !== 7'b1000000) begin failures++; $display("FAIL ext_make got=%b exp=1000000", key_held); end
      end
      if (k == 2) begin
        checks++;
        if (key_press_tick !== 7'b0000100) begin failures++; $display("FAIL plain_make got=%b exp=0000100", key_press_tick); end
      end
    end
    push_byte(8'h1D);  // completes the plain break started above
    e = sb.pop_front(); o = observe();
    checks++;
    if (o !== e) begin failures++; $display("FAIL extended_tail got=%h exp=%h", o, e); end
  endtask

  task automatic test_unmatched();
    logic [7:0] seq[5] = '{8'h4B, 8'hF0, 8'h4B, 8'h1C, 8'h2D};
    obs_t e, o;
    foreach (seq[k]) begin
      push_byte(seq[k]);
      e = sb.pop_front(); o = observe();
      checks++;
      if (o !== e) begin failures++; $display("FAIL unmatched byte=%0d got=%h exp=%h", k, o, e); end
      if (k < 3) begin
        checks++;
        if (o !== '0) begin failures++; $display("FAIL unmatched_quiet byte=%0d got=%h exp=0", k, o); end
      end
    end
    checks++;  // 1C then 2D back to back: both held, only R ticks last
    if (key_held !== 7'b0010001 || key_press_tick !== 7'b0010000)
      begin failures++; $display("FAIL back_to_back held=%b press=%b", key_held, key_press_tick); end
  endtask

  task automatic test_reset_mid();
    obs_t e, o;
    push_byte(8'hF0);
    e = sb.pop_front(); o = observe();
    checks++;
    if (o !== e) begin failures++; $display("FAIL prefix_quiet got=%h exp=%h", o, e); end
    reset = 1'b1; scan_done_tick = 1'b1; scan_code = 8'h1B;
    @(negedge clk);
    reset = 1'b0; scan_done_tick = 1'b0;
    m_held = '0; m_st = 0;
    o = observe();
    checks++;
    if (o !== '0) begin failures++; $display("FAIL reset_mid_clear got=%h exp=0", o); end
    push_byte(8'h23);
    e = sb.pop_front(); o = observe();
    checks++;
    if (o !== e) begin failures++; $display("FAIL reset_mid_make got=%h exp=%h", o, e); end
    checks++;
    if (key_held !== 7'b0000010 || key_release_tick !== '0)
      begin failures++; $display("FAIL reset_mid_held got=%b exp=0000010", key_held); end
  endtask

  task automatic test_repeat();
    logic [7:0]    rel_seq[3] = '{8'hF0, 8'h23, 8'h5A};
    logic [7:0]    pre_seq[1] = '{8'h5A};
    logic [NK-1:0] exp_rep;
    obs_t          e, o;
    foreach (pre_seq[k]) begin
      push_byte(pre_seq[k]);
      e = sb.pop_front(); o = observe();
      checks++;
      if (o !== e) begin failures++; $display("FAIL repeat_press got=%h exp=%h", o, e); end
    end
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      exp_rep = '0;
`ifdef KB_REPEAT_EN
      if (k == 20 || k == 25 || k == 30) exp_rep = 7'b0100000;
`endif
      checks++;
      if (key_repeat_tick !== exp_rep)
        begin failures++; $display("FAIL repeat_hold cycle=%0d got=%b exp=%b", k, key_repeat_tick, exp_rep); end
    end
    // F0 23 releases D (not the target) first; F0 5A then needs a fresh F0.
    push_byte(rel_seq[0]); e = sb.pop_front(); o = observe();
    checks++;
    if (o !== e) begin failures++; $display("FAIL repeat_f0 got=%h exp=%h", o, e); end
    push_byte(rel_seq[1]); e = sb.pop_front(); o = observe();
    checks++;
    if (o !== e) begin failures++; $display("FAIL repeat_rel_d got=%h exp=%h", o, e); end
    push_byte(8'hF0); e = sb.pop_front();
    push_byte(rel_seq[2]); e = sb.pop_front(); o = observe();
    checks++;
    if (o !== e) begin failures++; $display("FAIL repeat_rel_enter got=%h exp=%h", o, e); end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      checks++;
      if (key_repeat_tick !== '0)
        begin failures++; $display("FAIL repeat_after_release cycle=%0d got=%b exp=0", k, key_repeat_tick); end
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_typematic();
    test_extended();
    test_unmatched();
    test_reset_mid();
    test_repeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kb_multi_decoder.md
# kb_multi_decoder

Parametrised PS/2 scan-code decoder that tracks the held state of NUM_KEYS keys in a single instance, and replaces the one-instance-per-key keyboard controllers. It sits between ps2_rx (rx_done_tick, dout) and the game engine. It decodes make, break (F0) and extended (E0) sequences and emits per-key held levels plus one-cycle press and release ticks. Optionally it adds a software typematic repeat.

## Interface
Parameters:
- NUM_KEYS, 6: number of tracked keys.
- KEY_CODES, {9'h05A,9'h02D,9'h01B,9'h01D,9'h023,9'h01C}: packed NUM_KEYS×9 table. Key i occupies bits [9i+8:9i]. Bit 8 is the extended (E0) flag and bits 7:0 are the scan code.
- REPEAT_DELAY, 25_000_000: cycles from press to first repeat tick. Used only with KB_REPEAT_EN.
- REPEAT_PERIOD, 5_000_000: cycles between later repeat ticks. Used only with KB_REPEAT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- scan_done_tick  in  1  one-cycle strobe: scan_code is valid.
- scan_code  in  8  received byte.
- key_held  out  NUM_KEYS  level, bit i = key i currently down.
- key_press_tick  out  NUM_KEYS  one-cycle pulse on the up→down transition.
- key_release_tick  out  NUM_KEYS  one-cycle pulse on the down→up transition.
- key_repeat_tick  out  NUM_KEYS  one-cycle auto-repeat pulse. Tied to 0 without KB_REPEAT_EN.
- any_held  out  1  OR-reduction of key_held, registered.

## Operation
- Prefix FSM states: IDLE, EXT, BRK, EXT_BRK. The FSM advances only on cycles where scan_done_tick=1.
- IDLE transitions:
  - E0 → EXT.
  - F0 → BRK.
  - Any other byte → make event for {0,code}; stay IDLE.
- EXT transitions:
  - F0 → EXT_BRK.
  - E0 → stay EXT.
  - Any other byte → make event for {1,code}; go to IDLE.
- BRK: any byte → break event for {0,code}; go to IDLE.
- EXT_BRK: any byte → break event for {1,code}; go to IDLE.
- Make event: every key i whose KEY_CODES entry equals the event code sets key_held[i]. key_press_tick[i] pulses only if key_held[i] was 0. Hardware typematic re-makes therefore produce no tick.
- Break event: every matching key clears key_held[i]. key_release_tick[i] pulses only if key_held[i] was 1.
- Unmatched codes change no outputs. Duplicate table entries update all matching bits together.
- Reset sets every output to 0 and the FSM to IDLE, with repeat counters cleared. This holds mid-sequence: after a reset that follows an E0, the next byte is decoded from IDLE.

## Timing
- Outputs are registered. For the byte that completes an event, key_held, the ticks and any_held change on the first clk edge after the cycle in which scan_done_tick=1. Latency is 1 cycle.
- Tick outputs are high for exactly one cycle.
- Prefix bytes produce no output change.
- A scan_done_tick that coincides with reset is ignored.
- Multiple keys may be held simultaneously. Make and break events for different keys in successive bytes are independent.

## Configuration
- KB_REPEAT_EN defined:
  - A single repeat timer follows the most recently pressed key, stored as last_idx.
  - On that key's press tick the counter loads 0.
  - key_repeat_tick[last_idx] pulses when the count reaches REPEAT_DELAY-1, then every REPEAT_PERIOD cycles while that key stays held.
  - Releasing last_idx stops the timer; no retarget to other held keys.
  - A new press retargets and restarts the timer.
- KB_REPEAT_EN undefined: key_repeat_tick is constant 0 and no timer logic is built.

## Structure
- Package kb_pkg holds:
  - the FSM state enum;
  - the constants SC_EXT=8'hE0 and SC_BRK=8'hF0;
  - the named game key codes: W 1D, A 1C, S 1B, D 23, R 2D, ENTER 5A.
- Sub-module kb_repeat_timer contains the delay/period counter and target index. It is instantiated only under KB_REPEAT_EN.

## Test plan
- Press and release A: send 1C, then F0 1C. Expected: key_press_tick[0] pulses 1 cycle after the first tick and key_held[0]=1. After the final byte, key_release_tick[0] pulses and key_held[0]=0.
- Hardware typematic: send 1D 1D 1D. Expected: one key_press_tick[2], key_held[2] stays 1, no further ticks.
- Extended vs plain: table entry 9'h11D, send E0 1D then 1D. Expected: only the extended entry is set by the first make, and only the plain entry by the second.
- Reset mid-sequence: send F0, assert reset 1 cycle, send 23. Expected: key_held[1]=1 (decoded as a make), all other outputs 0.
- Unmatched code: send 4B and F0 4B. Expected: all outputs remain 0 and the FSM returns to IDLE.
- Repeat (KB_REPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=5): hold ENTER. Expected: repeat ticks at 20, 25, 30 cycles after the press tick, and none after F0 5A.
